// File: rtl/peripheral_bus_responder_if.sv
// Data-memory port bundle between the MIPS datapath (master) and the
// peripheral responder (slave).
interface peripheral_bus_responder_if;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemRd, MemWr, Addr, WriteData,
    input  ReadData
  );

  modport slave (
    input  MemRd, MemWr, Addr, WriteData,
    output ReadData
  );
endinterface

// File: rtl/peripheral_bus_responder.sv
// Memory-mapped timer/LED/switch/digit/systick block on the data-memory port
// of the single-cycle MIPS core; reads are combinational, writes land on clk.
module peripheral_bus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned TIMER_W   = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  peripheral_bus_responder_if.slave        bus,
  output logic [7:0]                       led,
  input  logic [7:0]                       switch,
  output logic [11:0]                      digi,
  output logic                             irqout
);

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_LED     = 3'd3,
    REG_SWITCH  = 3'd4,
    REG_DIGI    = 3'd5,
    REG_SYSTICK = 3'd6
  } reg_sel_e;

  localparam logic [TIMER_W-1:0] TL_ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] th_q, th_d;
  logic [TIMER_W-1:0] tl_q, tl_d;
  logic [2:0]         tcon_q, tcon_d;
  logic [7:0]         led_q, led_d;
  logic [11:0]        digi_q, digi_d;
  logic [31:0]        systick_q, systick_d;

  reg_sel_e sel;
  logic     hit;
  logic     wr_en;
  logic     overflow;

  // Word 7 (offset 0x1C) lies inside the 32-byte window but is unmapped.
  assign sel   = reg_sel_e'(bus.Addr[4:2]);
  assign hit   = (bus.Addr[31:5] == BASE_ADDR[31:5]) &&
                 (bus.Addr[1:0] == 2'b00) &&
                 (bus.Addr[4:2] != 3'd7);
  assign wr_en = bus.MemWr && hit;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    bus.ReadData = 32'h0;
    if (bus.MemRd && hit) begin
      case (sel)
        REG_TH:      bus.ReadData = 32'(th_q);
        REG_TL:      bus.ReadData = 32'(tl_q);
        REG_TCON:    bus.ReadData = {29'h0, tcon_q};
        REG_LED:     bus.ReadData = {24'h0, led_q};
        REG_SWITCH:  bus.ReadData = {24'h0, switch};
        REG_DIGI:    bus.ReadData = {20'h0, digi_q};
        REG_SYSTICK: bus.ReadData = systick_q;
        default:     bus.ReadData = 32'h0;
      endcase
    end
  end

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    overflow = tcon_q[0] && (tl_q == '1);
    if (tcon_q[0]) begin
      tl_d = overflow ? th_q : tl_q + TL_ONE;
    end

    // CPU writes override the timer step; a reload above already used old TH.
    if (wr_en) begin
      case (sel)
        REG_TH:   th_d   = bus.WriteData[TIMER_W-1:0];
        REG_TL:   tl_d   = bus.WriteData[TIMER_W-1:0];
        REG_TCON: tcon_d = bus.WriteData[2:0];
        REG_LED:  led_d  = bus.WriteData[7:0];
        REG_DIGI: digi_d = bus.WriteData[11:0];
        default:  ;
      endcase
    end

    // Overflow status wins over a same-cycle CPU clear so no interrupt is lost.
    if (overflow && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= 3'b000;
      led_q     <= 8'h00;
      digi_q    <= 12'h000;
      systick_q <= 32'h0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  assign led    = led_q;
  assign digi   = digi_q;
  assign irqout = tcon_q[2] & tcon_q[1];

endmodule
